// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit adder sequencer: drives one shared external 4-bit adder a nibble per clock,
// LSB nibble first, chaining the registered carry into the next nibble.
module nibble_serial_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*WORDS-1:0]   op_a,
    input  logic [4*WORDS-1:0]   op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_ci,
    input  logic [3:0]           add_s,
    input  logic                 add_co
);
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT                  state;
    logic [IDXW-1:0]        idx;
    logic                   carry;
    logic [WORDS-1:0][3:0]  regA;
    logic [WORDS-1:0][3:0]  regB;
    logic [WORDS-1:0][3:0]  sumReg;

    assign sum = sumReg;

    // NOTE: every register here uses <= so all updates see pre-edge values; blocking
    // assignments would let idx/carry changes leak into the same edge's decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            regA   <= '0;
            regB   <= '0;
            sumReg <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        regA   <= op_a;
                        regB   <= op_b;
                        carry  <= cin;
                        idx    <= '0;
                        sumReg <= '0;
                        cout   <= 1'b0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sumReg[idx] <= add_s;
                    carry       <= add_co;
                    if (idx == LAST_IDX) begin
                        // Signed overflow: like-signed operands producing an opposite-signed top nibble.
                        cout  <= add_co;
                        ovf   <= (regA[WORDS-1][3] == regB[WORDS-1][3]) &&
                                 (add_s[3] != regA[WORDS-1][3]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: defaults first so no path through this block leaves an output unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        if (state == RUN) begin
            add_a  = regA[idx];
            add_b  = regB[idx];
            add_ci = carry;
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: WORDS=4 directed cases plus a broad WORDS=2 sweep with back-to-back starts.
module tb_nibble_serial_add_ctrl;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } resT;

    logic        clk = 1'b0;
    int          checkCount = 0;
    int          passCount = 0;
    int          doneCount4 = 0;
    int          doneCount2 = 0;
    resT         q4[$];
    resT         q2[$];
    resT         exp4;
    resT         exp2;

    // WORDS=4 instance
    logic        rst4, start4, cin4, busy4, done4, cout4, ovf4, addCi4, addCo4;
    logic [15:0] opA4, opB4, sum4;
    logic [3:0]  addA4, addB4, addS4;

    // WORDS=2 instance
    logic        rst2, start2, cin2, busy2, done2, cout2, ovf2, addCi2, addCo2;
    logic [7:0]  opA2, opB2, sum2;
    logic [3:0]  addA2, addB2, addS2;

    always #5 clk = ~clk;

    // External 4-bit ripple adders, one per instance
    assign {addCo4, addS4} = {1'b0, addA4} + {1'b0, addB4} + {4'b0, addCi4};
    assign {addCo2, addS2} = {1'b0, addA2} + {1'b0, addB2} + {4'b0, addCi2};

    nibble_serial_add_ctrl #(.WORDS(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .op_a(opA4), .op_b(opB4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
        .add_a(addA4), .add_b(addB4), .add_ci(addCi4), .add_s(addS4), .add_co(addCo4)
    );

    nibble_serial_add_ctrl #(.WORDS(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .op_a(opA2), .op_b(opB2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2),
        .add_a(addA2), .add_b(addB2), .add_ci(addCi2), .add_s(addS2), .add_co(addCo2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got === expected) passCount++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    endtask

    function automatic resT model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  input int w);
        resT         r;
        logic [16:0] full;
        if (w == 16) begin
            full   = {1'b0, a} + {1'b0, b} + {16'b0, c};
            r.sum  = full[15:0];
            r.cout = full[16];
            r.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        end else begin
            full   = {9'b0, a[7:0]} + {9'b0, b[7:0]} + {16'b0, c};
            r.sum  = {8'b0, full[7:0]};
            r.cout = full[8];
            r.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done4) begin
            doneCount4++;
            if (q4.size() == 0) begin
                check("sb4_unexpected_done", {31'b0, done4}, 32'd0);
            end else begin
                exp4 = q4.pop_front();
                check("sb4_sum", sum4, exp4.sum);
                check("sb4_cout", cout4, exp4.cout);
                check("sb4_ovf", ovf4, exp4.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            doneCount2++;
            if (q2.size() == 0) begin
                check("sb2_unexpected_done", {31'b0, done2}, 32'd0);
            end else begin
                exp2 = q2.pop_front();
                check("sb2_sum", sum2, exp2.sum[7:0]);
                check("sb2_cout", cout2, exp2.cout);
                check("sb2_ovf", ovf2, exp2.ovf);
            end
        end
    end

    // One WORDS=4 add; optionally pulses a competing start at RUN cycle injectAt.
    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int injectAt, input string tag, output logic [3:0] ciTrace);
        int doneAt;
        int busyCycles;
        int dones0;
        @(negedge clk);
        opA4   = a;
        opB4   = b;
        cin4   = c;
        start4 = 1'b1;
        q4.push_back(model(a, b, c, 16));
        dones0     = doneCount4;
        doneAt     = 0;
        busyCycles = 0;
        ciTrace    = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start4 = (n == injectAt);
            if (n == injectAt) begin
                opA4 = 16'hAAAA;
                opB4 = 16'h5555;
            end
            if (busy4) busyCycles++;
            if (n <= 4) ciTrace[n-1] = addCi4;
            if (done4 && doneAt == 0) doneAt = n;
        end
        check({tag, "_done_latency"}, doneAt, 32'd5);
        check({tag, "_busy_cycles"}, busyCycles, 32'd4);
        check({tag, "_done_pulses"}, doneCount4 - dones0, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ci;
        int         dones0;
        int         waited;
        logic [7:0] bv;

        rst4 = 1'b1; start4 = 1'b0; cin4 = 1'b0; opA4 = '0; opB4 = '0;
        rst2 = 1'b1; start2 = 1'b0; cin2 = 1'b0; opA2 = '0; opB2 = '0;
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        check("rst_busy", busy4, 32'd0);
        check("rst_done", done4, 32'd0);
        check("rst_sum", sum4, 32'd0);
        check("rst_cout", cout4, 32'd0);
        check("rst_ovf", ovf4, 32'd0);
        check("rst_add_a", addA4, 32'd0);

        run4(16'h1234, 16'h4321, 1'b0, 0, "t1", ci);
        check("t1_sum", sum4, 32'h5555);
        check("t1_cout", cout4, 32'd0);
        check("t1_ovf", ovf4, 32'd0);
        check("idle_add_a", addA4, 32'd0);
        check("idle_add_b", addB4, 32'd0);
        check("idle_add_ci", addCi4, 32'd0);

        run4(16'hFFFF, 16'h0001, 1'b0, 0, "t2", ci);
        check("t2_sum", sum4, 32'h0000);
        check("t2_cout", cout4, 32'd1);
        check("t2_ovf", ovf4, 32'd0);
        check("t2_ci_trace", ci, 32'b1110);

        run4(16'h7FFF, 16'h0001, 1'b0, 0, "t3a", ci);
        check("t3a_sum", sum4, 32'h8000);
        check("t3a_cout", cout4, 32'd0);
        check("t3a_ovf", ovf4, 32'd1);

        run4(16'h8000, 16'h8000, 1'b0, 0, "t3b", ci);
        check("t3b_sum", sum4, 32'h0000);
        check("t3b_cout", cout4, 32'd1);
        check("t3b_ovf", ovf4, 32'd1);

        run4(16'h0000, 16'h0000, 1'b1, 2, "t4", ci);
        check("t4_sum", sum4, 32'h0001);
        check("t4_cout", cout4, 32'd0);

        // Reset in the middle of a run discards the partial result.
        @(negedge clk);
        opA4 = 16'hFFFF; opB4 = 16'hFFFF; cin4 = 1'b0; start4 = 1'b1;
        dones0 = doneCount4;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        check("t5_busy_before_rst", busy4, 32'd1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("t5_busy", busy4, 32'd0);
        check("t5_sum", sum4, 32'd0);
        check("t5_cout", cout4, 32'd0);
        check("t5_done", done4, 32'd0);
        check("t5_add_a", addA4, 32'd0);
        repeat (8) @(negedge clk);
        check("t5_no_done", doneCount4 - dones0, 32'd0);

        run4(16'hFFFF, 16'hFFFF, 1'b1, 0, "t6", ci);
        check("t6_sum", sum4, 32'hFFFF);
        check("t6_cout", cout4, 32'd1);

        // WORDS=2 sweep: all A, B on a stride-17 grid including 0x00/0xFF, both cin.
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    bv     = 8'(bi * 17);
                    opA2   = 8'(a);
                    opB2   = bv;
                    cin2   = c[0];
                    start2 = 1'b1;
                    q2.push_back(model({8'b0, opA2}, {8'b0, bv}, c[0], 8));
                    @(negedge clk);
                    start2 = 1'b0;
                    waited = 0;
                    while (!done2 && waited < 8) begin
                        @(negedge clk);
                        waited++;
                    end
                    check("w2_latency", waited, 32'd2);
                    @(negedge clk);
                end
            end
        end
        repeat (6) @(negedge clk);
        check("sb2_drained", q2.size(), 32'd0);
        check("sb4_drained", q4.size(), 32'd0);
        check("w2_done_count", doneCount2, 32'd8192);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
